core_run_ctrl: RTL and testbench
================================

Name: core_run_ctrl

Overview:
- Synthesizable run controller for the single-cycle/pipelined RISC-V core.
- Derives a core clock-enable (`core_en`) from `CLOCK_50` using a programmable divisor.
- Supports halt, free-run, single-step and run-N modes, and stops on core `hlt`, an exhausted step count or a cycle timeout.
- Sits between the board clock and the core, and replaces fixed clock division and time-based bench stops.

Parameters:
- DIV_W, 16: width of the divisor input.
- CNT_W, 32: width of the step count, timeout and cycle counter.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- div  in  DIV_W  enable divisor; one `core_en` pulse every div+1 clocks.
- mode  in  2  run mode: 0 HALT, 1 FREE, 2 STEP, 3 RUNN.
- start  in  1  single-cycle start request.
- abort  in  1  single-cycle stop request.
- step_n  in  CNT_W  pulse budget for RUNN.
- timeout  in  CNT_W  maximum pulses per run; 0 disables the timeout.
- hlt  in  1  halt flag from the core.
- core_en  out  1  core clock-enable.
- running  out  1  high while in RUN.
- done  out  1  one-cycle pulse on entry to STOPPED.
- halt_cause  out  2  0 abort, 1 hlt, 2 count, 3 timeout.
- cycles  out  CNT_W  `core_en` pulses issued since the last start.

Behaviour:
- Reset values: state IDLE; core_en 0, running 0, done 0, halt_cause 0, cycles 0; divcnt 0, remaining 0.
- Reset mid-run takes effect at the next edge; no `core_en` in the following cycle.
- FSM states: IDLE, RUN, STOPPED.
- IDLE/STOPPED, start=1 with mode != 0, at edge k:
  - Latch div_q, mode_q and timeout_q.
  - remaining = 1 for STEP, step_n for RUNN.
  - Clear cycles and divcnt; go to RUN at k+1.
- start with mode 0 is ignored.
- RUNN with step_n = 0: go directly to STOPPED, cause 2; no `core_en` is issued.
- RUN:
  - core_en = (state == RUN) && (divcnt == div_q). It is decoded from registers only, with no input-to-output path.
  - divcnt wraps to 0 on a pulse, otherwise increments.
  - First pulse occurs in cycle k+1+div. With div=0, `core_en` is high every RUN cycle.
  - On each pulse, cycles increments and saturates at all-ones.
  - On each pulse in STEP/RUNN mode, remaining decrements.
- Stop conditions, evaluated at every RUN edge with priority reset > abort > hlt > count > timeout:
  - abort: STOPPED, cause 0.
  - hlt: STOPPED, cause 1. Sampled on any RUN cycle, not only on pulse cycles.
  - count: core_en && remaining == 1 in STEP/RUNN → STOPPED, cause 2.
  - timeout: core_en && timeout_q != 0 && cycles+1 == timeout_q → STOPPED, cause 3.
- A `core_en` already high in the sampling cycle is never withdrawn. No pulse occurs after entering STOPPED.
- `running` equals (state == RUN).
- `done` is high only in the first STOPPED cycle.
- `halt_cause` and `cycles` hold until the next start.
- In RUN:
  - start is ignored.
  - Changes to mode, div, step_n and timeout are ignored, because all are latched at start.
  - FREE runs until abort, hlt or timeout.
- STOPPED to RUN on a valid start. STOPPED to IDLE only via reset.
- abort in IDLE/STOPPED: no effect.

Decomposition:
- Package core_run_pkg holds:
  - the mode encodings MODE_HALT/FREE/STEP/RUNN;
  - the cause encodings CAUSE_ABORT/HLT/COUNT/TIMEOUT;
  - the state enum.
- One natural sub-module, clk_en_div: divisor counter with load/clear, producing the tick.
- FSM and counters stay in the top level.

Test Plan:
- reset; div=3, mode=FREE, start at cycle 0 → core_en high in cycles 4, 8, 12…; cycles=3 after cycle 12; running=1.
- div=0, mode=RUNN, step_n=5, start → exactly 5 consecutive core_en cycles; done pulse in cycle 6; halt_cause=2; cycles=5.
- div=1, mode=STEP, start twice with a gap → one pulse per start; cycles=1 after each; done twice.
- div=0, FREE, timeout=10, hlt asserted with pulse 7 → stops with cause 1; cycles=7.
- Repeat without hlt → stops with cause 3; cycles=10.
- RUNN step_n=4, timeout=4 → cause 2 (count beats timeout). Same run with abort at pulse 2 → cause 0, cycles=2.
- Reset asserted mid-FREE run → next cycle core_en=0, running=0, cycles=0. start in RUN and mode change in RUN → no effect on pulse spacing.

Source files
------------

// File: rtl/core_run_pkg.sv
// Shared encodings for the core run controller: run modes, stop causes and FSM states.
package core_run_pkg;

  localparam logic [1:0] MODE_HALT = 2'd0;
  localparam logic [1:0] MODE_FREE = 2'd1;
  localparam logic [1:0] MODE_STEP = 2'd2;
  localparam logic [1:0] MODE_RUNN = 2'd3;

  localparam logic [1:0] CAUSE_ABORT   = 2'd0;
  localparam logic [1:0] CAUSE_HLT     = 2'd1;
  localparam logic [1:0] CAUSE_COUNT   = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STOPPED = 2'd2
  } run_state_t;

endpackage

// File: rtl/clk_en_div.sv
// Divisor counter: latches the divisor on load and emits one tick every div+1 run cycles.
module clk_en_div #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         run,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] div_q;
  logic [W-1:0] divcnt;

  // Tick is decoded from registers only, so inputs never reach core_en combinationally.
  assign tick = run && (divcnt == div_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      divcnt <= '0;
    end else if (load) begin
      div_q  <= div;
      divcnt <= '0;
    end else if (run) begin
      divcnt <= tick ? '0 : divcnt + W'(1);
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller for the RISC-V core: generates core_en and stops on abort, hlt,
// exhausted step budget or cycle timeout.
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] step_n,
  input  logic [CNT_W-1:0] timeout,
  input  logic             hlt,
  output logic             core_en,
  output logic             running,
  output logic             done,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycles,
  output run_state_t       state_dbg
);

  run_state_t       state, state_n;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] timeout_q;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] cycles_inc;
  logic             load, stop, counted, stop_count, stop_to;
  logic [1:0]       cause_n;

  clk_en_div #(.W(DIV_W)) u_div (
    .clk   (CLOCK_50),
    .reset (reset),
    .load  (load),
    .run   (state == ST_RUN),
    .div   (div),
    .tick  (core_en)
  );

  assign running    = (state == ST_RUN);
  assign state_dbg  = state;
  assign cycles_inc = cycles + CNT_W'(1);
  assign counted    = (mode_q == MODE_STEP) || (mode_q == MODE_RUNN);
  assign stop_count = core_en && counted && (remaining == CNT_W'(1));
  assign stop_to    = core_en && (timeout_q != '0) && (cycles_inc == timeout_q);

  always_comb begin
    state_n = state;
    load    = 1'b0;
    stop    = 1'b0;
    cause_n = halt_cause;
    case (state)
      ST_IDLE, ST_STOPPED: begin
        if (start && (mode != MODE_HALT)) begin
          load = 1'b1;
          // An empty RUNN budget completes immediately without issuing a pulse.
          if ((mode == MODE_RUNN) && (step_n == '0)) begin
            stop    = 1'b1;
            cause_n = CAUSE_COUNT;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          stop    = 1'b1;
          cause_n = CAUSE_ABORT;
        end else if (hlt) begin
          stop    = 1'b1;
          cause_n = CAUSE_HLT;
        end else if (stop_count) begin
          stop    = 1'b1;
          cause_n = CAUSE_COUNT;
        end else if (stop_to) begin
          stop    = 1'b1;
          cause_n = CAUSE_TIMEOUT;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (stop) state_n = ST_STOPPED;
    else if (load) state_n = ST_RUN;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // A pulse issued in the stopping cycle is still counted.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      done       <= 1'b0;
      halt_cause <= CAUSE_ABORT;
      cycles     <= '0;
      remaining  <= '0;
      mode_q     <= MODE_HALT;
      timeout_q  <= '0;
    end else begin
      done       <= stop;
      halt_cause <= cause_n;
      if (load) begin
        mode_q    <= mode;
        timeout_q <= timeout;
        cycles    <= '0;
        if (mode == MODE_STEP)      remaining <= CNT_W'(1);
        else if (mode == MODE_RUNN) remaining <= step_n;
        else                        remaining <= '0;
      end else if (core_en) begin
        if (cycles != '1) cycles <= cycles_inc;
        if (counted) remaining <= remaining - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: one task per scenario with hand-computed expectations.
module tb_core_run_ctrl;
  import core_run_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] div;
  logic [1:0]  mode;
  logic        start;
  logic        abort;
  logic [31:0] step_n;
  logic [31:0] timeout;
  logic        hlt;
  logic        core_en;
  logic        running;
  logic        done;
  logic [1:0]  halt_cause;
  logic [31:0] cycles;
  run_state_t  state_dbg;

  int tests_run;
  int tests_failed;

  core_run_ctrl #(.DIV_W(16), .CNT_W(32)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .div        (div),
    .mode       (mode),
    .start      (start),
    .abort      (abort),
    .step_n     (step_n),
    .timeout    (timeout),
    .hlt        (hlt),
    .core_en    (core_en),
    .running    (running),
    .done       (done),
    .halt_cause (halt_cause),
    .cycles     (cycles),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Returns in the first cycle after the start edge.
  task automatic do_start(input logic [1:0] m, input logic [15:0] d,
                          input logic [31:0] n, input logic [31:0] to);
    mode = m; div = d; step_n = n; timeout = to;
    start = 1'b1;
    step_clk();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; div = '0; mode = MODE_HALT; start = 0; abort = 0;
    step_n = '0; timeout = '0; hlt = 0;
    step_clk(); step_clk();
    reset = 1'b0;
    tests_run++;
    if (state_dbg !== ST_IDLE || core_en !== 1'b0 || running !== 1'b0 || done !== 1'b0 ||
        halt_cause !== 2'd0 || cycles !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset: state=%0d en=%b run=%b done=%b cause=%0d cycles=%0d, required 0 for all",
               state_dbg, core_en, running, done, halt_cause, cycles);
    end
    // start with mode HALT is ignored
    do_start(MODE_HALT, 16'd0, 32'd0, 32'd0);
    tests_run++;
    if (state_dbg !== ST_IDLE || running !== 1'b0 || core_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_start: state=%0d run=%b en=%b, required IDLE/0/0", state_dbg, running, core_en);
    end
  endtask

  task automatic test_free_div3();
    logic exp;
    do_start(MODE_FREE, 16'd3, 32'd0, 32'd0);
    for (int c = 1; c <= 12; c++) begin
      exp = (c % 4 == 0);
      tests_run++;
      if (core_en !== exp) begin
        tests_failed++;
        $display("FAIL free_en c%0d: got %b required %b", c, core_en, exp);
      end
      step_clk();
    end
    tests_run++;
    if (cycles !== 32'd3 || running !== 1'b1) begin
      tests_failed++;
      $display("FAIL free_cycles: cycles=%0d run=%b, required 3/1", cycles, running);
    end
    abort = 1'b1;
    step_clk();
    abort = 1'b0;
    tests_run++;
    if (done !== 1'b1 || running !== 1'b0 || halt_cause !== CAUSE_ABORT || cycles !== 32'd3 || core_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL free_abort: done=%b run=%b cause=%0d cycles=%0d en=%b, required 1/0/0/3/0",
               done, running, halt_cause, cycles, core_en);
    end
    step_clk();
    tests_run++;
    if (done !== 1'b0 || halt_cause !== CAUSE_ABORT || state_dbg !== ST_STOPPED) begin
      tests_failed++;
      $display("FAIL free_hold: done=%b cause=%0d state=%0d, required 0/0/STOPPED", done, halt_cause, state_dbg);
    end
  endtask

  task automatic test_runn5();
    do_start(MODE_RUNN, 16'd0, 32'd5, 32'd0);
    for (int c = 1; c <= 5; c++) begin
      tests_run++;
      if (core_en !== 1'b1 || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL runn_en c%0d: en=%b done=%b, required 1/0", c, core_en, done);
      end
      step_clk();
    end
    tests_run++;
    if (core_en !== 1'b0 || done !== 1'b1 || halt_cause !== CAUSE_COUNT || cycles !== 32'd5) begin
      tests_failed++;
      $display("FAIL runn_stop: en=%b done=%b cause=%0d cycles=%0d, required 0/1/2/5",
               core_en, done, halt_cause, cycles);
    end
    step_clk();
    tests_run++;
    if (done !== 1'b0 || core_en !== 1'b0 || cycles !== 32'd5) begin
      tests_failed++;
      $display("FAIL runn_after: done=%b en=%b cycles=%0d, required 0/0/5", done, core_en, cycles);
    end
  endtask

  task automatic test_step_twice();
    for (int r = 0; r < 2; r++) begin
      do_start(MODE_STEP, 16'd1, 32'd9, 32'd0);
      tests_run++;
      if (core_en !== 1'b0 || running !== 1'b1 || cycles !== 32'd0) begin
        tests_failed++;
        $display("FAIL step%0d_c1: en=%b run=%b cycles=%0d, required 0/1/0", r, core_en, running, cycles);
      end
      step_clk();
      tests_run++;
      if (core_en !== 1'b1) begin
        tests_failed++;
        $display("FAIL step%0d_c2: en=%b, required 1", r, core_en);
      end
      step_clk();
      tests_run++;
      if (core_en !== 1'b0 || done !== 1'b1 || halt_cause !== CAUSE_COUNT || cycles !== 32'd1) begin
        tests_failed++;
        $display("FAIL step%0d_stop: en=%b done=%b cause=%0d cycles=%0d, required 0/1/2/1",
                 r, core_en, done, halt_cause, cycles);
      end
      for (int g = 0; g < 3; g++) begin
        step_clk();
        tests_run++;
        if (core_en !== 1'b0 || done !== 1'b0) begin
          tests_failed++;
          $display("FAIL step%0d_gap: en=%b done=%b, required 0/0", r, core_en, done);
        end
      end
    end
  endtask

  task automatic test_hlt_and_timeout();
    do_start(MODE_FREE, 16'd0, 32'd0, 32'd10);
    for (int c = 1; c <= 7; c++) begin
      if (c == 7) hlt = 1'b1;
      tests_run++;
      if (core_en !== 1'b1) begin
        tests_failed++;
        $display("FAIL hlt_en c%0d: en=%b, required 1", c, core_en);
      end
      step_clk();
    end
    hlt = 1'b0;
    tests_run++;
    if (core_en !== 1'b0 || done !== 1'b1 || halt_cause !== CAUSE_HLT || cycles !== 32'd7) begin
      tests_failed++;
      $display("FAIL hlt_stop: en=%b done=%b cause=%0d cycles=%0d, required 0/1/1/7",
               core_en, done, halt_cause, cycles);
    end
    do_start(MODE_FREE, 16'd0, 32'd0, 32'd10);
    for (int c = 1; c <= 10; c++) step_clk();
    tests_run++;
    if (core_en !== 1'b0 || done !== 1'b1 || halt_cause !== CAUSE_TIMEOUT || cycles !== 32'd10) begin
      tests_failed++;
      $display("FAIL timeout_stop: en=%b done=%b cause=%0d cycles=%0d, required 0/1/3/10",
               core_en, done, halt_cause, cycles);
    end
  endtask

  task automatic test_count_vs_timeout();
    do_start(MODE_RUNN, 16'd0, 32'd4, 32'd4);
    for (int c = 1; c <= 4; c++) step_clk();
    tests_run++;
    if (done !== 1'b1 || halt_cause !== CAUSE_COUNT || cycles !== 32'd4) begin
      tests_failed++;
      $display("FAIL count_prio: done=%b cause=%0d cycles=%0d, required 1/2/4", done, halt_cause, cycles);
    end
    do_start(MODE_RUNN, 16'd0, 32'd4, 32'd4);
    step_clk();
    abort = 1'b1;
    step_clk();
    abort = 1'b0;
    tests_run++;
    if (done !== 1'b1 || halt_cause !== CAUSE_ABORT || cycles !== 32'd2 || core_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_prio: done=%b cause=%0d cycles=%0d en=%b, required 1/0/2/0",
               done, halt_cause, cycles, core_en);
    end
    // empty RUNN budget stops at once
    do_start(MODE_RUNN, 16'd0, 32'd0, 32'd0);
    tests_run++;
    if (state_dbg !== ST_STOPPED || done !== 1'b1 || halt_cause !== CAUSE_COUNT ||
        cycles !== 32'd0 || core_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL runn_zero: state=%0d done=%b cause=%0d cycles=%0d en=%b, required STOPPED/1/2/0/0",
               state_dbg, done, halt_cause, cycles, core_en);
    end
  endtask

  task automatic test_run_ignores_changes();
    logic exp;
    do_start(MODE_FREE, 16'd3, 32'd0, 32'd0);
    step_clk();
    start = 1'b1; mode = MODE_STEP; div = 16'd0; step_n = 32'd1; timeout = 32'd1;
    step_clk();
    start = 1'b0;
    for (int c = 3; c <= 12; c++) begin
      exp = (c % 4 == 0);
      tests_run++;
      if (core_en !== exp || running !== 1'b1) begin
        tests_failed++;
        $display("FAIL ignore_en c%0d: en=%b run=%b, required %b/1", c, core_en, running, exp);
      end
      step_clk();
    end
    tests_run++;
    if (cycles !== 32'd3) begin
      tests_failed++;
      $display("FAIL ignore_cycles: cycles=%0d, required 3", cycles);
    end
  endtask

  task automatic test_reset_mid_run();
    do_start(MODE_FREE, 16'd0, 32'd0, 32'd0);
    step_clk(); step_clk();
    reset = 1'b1;
    step_clk();
    reset = 1'b0;
    tests_run++;
    if (core_en !== 1'b0 || running !== 1'b0 || cycles !== 32'd0 || state_dbg !== ST_IDLE || halt_cause !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: en=%b run=%b cycles=%0d state=%0d cause=%0d, required 0/0/0/IDLE/0",
               core_en, running, cycles, state_dbg, halt_cause);
    end
    abort = 1'b1;
    step_clk();
    abort = 1'b0;
    tests_run++;
    if (state_dbg !== ST_IDLE || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_idle: state=%0d done=%b, required IDLE/0", state_dbg, done);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_free_div3();
    test_runn5();
    test_step_twice();
    test_hlt_and_timeout();
    test_count_vs_timeout();
    test_run_ignores_changes();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
